pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
Program-counter stage directly upstream of the 32-bit adder. Holds the architectural PC, drives the adder operands (PC, PC_STEP), and consumes the adder's Sum as the sequential next PC. Presents the PC to instruction memory over a valid/ready handshake. Supports stalls, branch redirects, and buffering of one pending redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 32'd4, constant driven on the adder B operand.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
stall  input  1  pipeline hold; blocks PC advance
branch_taken  input  1  one-cycle redirect request
branch_target  input  32  redirect address, sampled when branch_taken=1
fetch_ready  input  1  instruction memory accepts the current PC
adder_sum  input  32  Sum from the downstream adder (adder_a + adder_b)
adder_a  output  32  adder A operand = pc
adder_b  output  32  adder B operand = PC_STEP
pc  output  32  current fetch address
pc_valid  output  1  pc is valid for fetch
redirect_pending  output  1  a buffered redirect is waiting to be applied
fetch_count  output  32  number of accepted fetches since reset

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, mid-operation included):
  - pc=RESET_PC, pc_valid=0, redirect_pending=0, pending target=0, fetch_count=0, state=BOOT.
- FSM states: BOOT, FETCH, HALT (HALT exists only with the optional feature).
  - BOOT -> FETCH unconditionally on the first clock edge after rst deasserts; pc_valid=1 from that cycle.
  - Any branch_taken seen during BOOT is buffered.
- Accept condition: accept = pc_valid & fetch_ready & ~stall.
  - On accept, fetch_count increments by 1 (wraps mod 2^32).
- Next-PC selection on accept, highest priority first:
  1. branch_taken=1 this cycle -> pc <= {branch_target[31:2],2'b00}; clear pending.
  2. redirect_pending=1 -> pc <= pending target; clear pending.
  3. Otherwise -> pc <= adder_sum.
- No accept, branch_taken=1:
  - Latch the aligned target into the pending register; redirect_pending=1 next cycle.
  - A later redirect overwrites an earlier unconsumed one; the newest wins.
- No accept, branch_taken=0: pc and pending are held.
- Adder interface:
  - adder_a=pc and adder_b=PC_STEP, combinationally.
  - adder_sum is used directly with no latency; it wraps mod 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000).
- stall=1 overrides fetch_ready.
  - pc_valid stays 1 while stalled in FETCH.
  - pc must not change while pc_valid=1 and the fetch is unaccepted.
- Latency:
  - Redirect on an accept cycle: target is visible on pc on the next cycle.
  - Buffered redirect: applied on the first accept after capture.
- All outputs are registered except adder_a and adder_b.

Optional Feature:
Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - branch_taken with branch_target[1:0]!=0 sends the FSM to HALT on the next edge.
  - In HALT: pc_valid=0, pc frozen at the last valid PC, extra output misalign_trap=1.
  - HALT is left only by rst.
  - The misaligned target is not loaded or buffered.
- Undefined:
  - Target bits [1:0] are silently forced to 0.
  - No HALT state and no misalign_trap port.

Test Plan:
- Reset, then fetch_ready=1, stall=0 for 4 cycles -> pc_valid rises one cycle after reset release; pc sequence 0x0,0x4,0x8,0xC; fetch_count=4.
- At pc=0x8, stall=1 for 3 cycles, then release -> pc held at 0x8 with pc_valid=1 throughout; next pc=0xC.
- stall=1, branch_taken=1 with target 0x100 -> redirect_pending=1; then branch_taken=1 with target 0x200 while still stalled; release stall -> pc=0x200, redirect_pending=0.
- Pending target 0x200, accept cycle with branch_taken=1 and target 0x300 -> pc=0x300 (the live redirect wins); pending cleared.
- RESET_PC=32'hFFFF_FFF8 -> pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert rst mid-stall with a redirect pending -> pc=RESET_PC, pc_valid=0 and redirect_pending=0 immediately (before the next clock edge).
- With PC_MISALIGN_TRAP_EN defined, branch_target=0x102 -> HALT, pc_valid=0, misalign_trap=1 until rst.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus of pc_fetch_ctrl: the instruction-memory valid/ready handshake
// plus the operand/sum connection to the external 32-bit adder.
interface pc_fetch_ctrl_if;
  logic [31:0] pc;
  logic        pc_valid;
  logic        fetch_ready;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic [31:0] adder_sum;

  modport master (
    output pc, pc_valid, adder_a, adder_b,
    input  fetch_ready, adder_sum
  );

  modport slave (
    input  pc, pc_valid, adder_a, adder_b,
    output fetch_ready, adder_sum
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter stage: holds the PC, feeds the external adder and takes its sum as next PC.
// Define PC_MISALIGN_TRAP_EN to trap misaligned branch targets into a HALT state.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_ctrl_if.master        fif,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  output logic                   redirect_pending,
  output logic [31:0]            fetch_count
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                   misalign_trap
`endif
);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;
`else
  typedef enum logic [0:0] {StBoot, StFetch} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        accept;
  logic        misalign;
  logic        frozen;
  logic [31:0] target_aligned;

  assign accept         = valid_q & fif.fetch_ready & ~stall;
  assign target_aligned = {branch_target[31:2], 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign misalign = branch_taken & (branch_target[1:0] != 2'b00);
  assign frozen   = (state_q == StHalt);
`else
  // Low target bits are dropped on the floor when the trap is not built in.
  logic unused_target_lsb;
  assign unused_target_lsb = ^branch_target[1:0];
  assign misalign          = 1'b0;
  assign frozen            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = state_q;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    if (misalign && state_q != StHalt) begin
      state_d = StHalt;
    end
`endif
  end

  // Output / datapath next-state logic
  always_comb begin
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    count_d      = count_q;
    if (accept) begin
      count_d = count_q + 32'd1;
    end
    if (!frozen && !misalign) begin
      if (accept) begin
        if (branch_taken) begin
          pc_d         = target_aligned;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          pc_d         = pend_q;
          pend_valid_d = 1'b0;
        end else begin
          pc_d = fif.adder_sum;
        end
      end else if (branch_taken) begin
        // Newest unconsumed redirect overwrites any older one.
        pend_d       = target_aligned;
        pend_valid_d = 1'b1;
      end
    end
    valid_d = (state_d == StFetch);
`ifdef PC_MISALIGN_TRAP_EN
    trap_d = (state_d == StHalt);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= 32'h0;
      pend_valid_q <= 1'b0;
      count_q      <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
  assign misalign_trap = trap_q;
`endif

  assign fif.pc           = pc_q;
  assign fif.pc_valid     = valid_q;
  assign fif.adder_a      = pc_q;
  assign fif.adder_b      = PC_STEP;
  assign redirect_pending = pend_valid_q;
  assign fetch_count      = count_q;

endmodule
